c_74lvc161: RTL and testbench



---
 rtl/c_74lvc161_pkg.sv | 26 ++
 rtl/c_74lvc161_bit.sv | 40 ++++
 rtl/c_74lvc161.sv | 47 ++++
 tb/tb_c_74lvc161.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/c_74lvc161_pkg.sv
// Shared constants and helpers for the c_74lvc161 presettable counter.
package c_74lvc161_pkg;

  localparam int DEFAULT_WIDTH = 4;

  // What a single counter stage does at the next rising clock edge
  typedef enum logic [1:0] {
    STAGE_HOLD   = 2'd0,
    STAGE_TOGGLE = 2'd1,
    STAGE_LOAD   = 2'd2
  } stage_op_t;

  // Loading beats counting; a stage toggles only when every lower stage
  // is at one and the counter is enabled (carry-in high).
  function automatic stage_op_t stage_op(input logic load, input logic cin);
    stage_op_t op;
    op = STAGE_HOLD;
    if (load) begin
      op = STAGE_LOAD;
    end else if (cin) begin
      op = STAGE_TOGGLE;
    end
    return op;
  endfunction

endpackage

// File: rtl/c_74lvc161_bit.sv
// One toggle/load flip-flop stage of the synchronous binary counter.
module c_74lvc161_bit
  import c_74lvc161_pkg::*;
(
  input  logic CP,
  input  logic CR,
  input  logic load,
  input  logic d,
  input  logic cin,
  output logic q,
  output logic cout
);

  stage_op_t op;

  // Decide this edge's action from the load request and the carry-in
  always_comb begin
    op = STAGE_HOLD;
    op = stage_op(load, cin);
  end

  // Stage flip-flop, cleared immediately whenever CR is low
  always_ff @(posedge CP or negedge CR) begin
    if (!CR) begin
      q <= 1'b0;
    end else begin
      case (op)
        STAGE_LOAD:   q <= d;
        STAGE_TOGGLE: q <= ~q;
        default:      q <= q;
      endcase
    end
  end

  // Ripple the count-enable up to the next stage
  always_comb begin
    cout = q & cin;
  end

endmodule

// File: rtl/c_74lvc161.sv
// Synchronous presettable binary counter with asynchronous master reset,
// functionally equivalent to the 74LVC161 and cascadable through TC/CET.
module c_74lvc161
  import c_74lvc161_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CP,
  input  logic             CR,
  input  logic             PE,
  input  logic             CEP,
  input  logic             CET,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             TC
);

  logic [WIDTH:0] carry;
  logic           load;

  // Stage-0 carry-in is the combined enable; PE is active-low
  always_comb begin
    carry[0] = CEP & CET;
    load     = ~PE;
  end

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_stage
      c_74lvc161_bit u_bit (
        .CP   (CP),
        .CR   (CR),
        .load (load),
        .d    (D[i]),
        .cin  (carry[i]),
        .q    (Q[i]),
        .cout (carry[i+1])
      );
    end
  endgenerate

  // Terminal count depends only on CET and the all-ones state, never on CEP
  always_comb begin
    TC = CET & (&Q);
  end

endmodule

// File: tb/tb_c_74lvc161.sv
// Self-checking bench for c_74lvc161 with directed and random stimulus.
module tb_c_74lvc161;

  localparam int W = 4;
  localparam int MAXV = (1 << W) - 1;

  logic         CP = 1'b0;
  logic         CR;
  logic         PE;
  logic         CEP;
  logic         CET;
  logic [W-1:0] D;
  logic [W-1:0] Q;
  logic         TC;

  int vectors = 0;
  int miscompares = 0;
  int model = 0;

  c_74lvc161 #(.WIDTH(W)) dut (
    .CP  (CP),
    .CR  (CR),
    .PE  (PE),
    .CEP (CEP),
    .CET (CET),
    .D   (D),
    .Q   (Q),
    .TC  (TC)
  );

  // 10 ns clock, rising edges at 5, 15, 25 ...
  always #5 CP = ~CP;

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic checkState(input string tag);
    logic [7:0] expQ;
    logic [7:0] expTc;
    expQ  = 8'(model);
    expTc = {7'd0, (CET === 1'b1) && (model == MAXV)};
    checkOutput({tag, "_q"}, {4'd0, Q}, expQ);
    checkOutput({tag, "_tc"}, {7'd0, TC}, expTc);
  endtask

  // Drive one cycle's inputs on the falling edge, update the model at the
  // rising edge, then check just after it.
  task automatic applyStimulus(input string tag, input logic cr, input logic pe,
                               input logic cep, input logic cet, input logic [W-1:0] d);
    @(negedge CP);
    CR = cr; PE = pe; CEP = cep; CET = cet; D = d;
    @(posedge CP);
    if (!cr)            model = 0;
    else if (!pe)       model = int'(d);
    else if (cep && cet) model = (model + 1) % (MAXV + 1);
    #1;
    checkState(tag);
  endtask

  // Pulse CR low between clock edges and confirm the immediate clear
  task automatic asyncReset(input string tag);
    #1;
    CR = 1'b0;
    model = 0;
    #1;
    checkState(tag);
    #1;
    CR = 1'b1;
  endtask

  initial begin
    CR = 1'b1; PE = 1'b1; CEP = 1'b0; CET = 1'b1; D = '0;

    // Reset with Q unknown, held low for 20 ns across edges
    @(negedge CP);
    #2;
    CR = 1'b0;
    model = 0;
    #1;
    checkState("reset_now");
    #20;
    checkState("reset_held");
    applyStimulus("step1", 1'b1, 1'b1, 1'b1, 1'b1, 4'd0);
    applyStimulus("step2", 1'b1, 1'b1, 1'b1, 1'b1, 4'd0);
    applyStimulus("step3", 1'b1, 1'b1, 1'b1, 1'b1, 4'd0);
    checkOutput("step3_val", {4'd0, Q}, 8'd3);

    // Load then count through the wrap
    applyStimulus("load_e", 1'b1, 1'b0, 1'b1, 1'b1, 4'hE);
    applyStimulus("cnt_f", 1'b1, 1'b1, 1'b1, 1'b1, 4'h0);
    checkOutput("tc_at_f", {7'd0, TC}, 8'd1);
    applyStimulus("wrap0", 1'b1, 1'b1, 1'b1, 1'b1, 4'h0);
    checkOutput("tc_after_wrap", {7'd0, TC}, 8'd0);

    // Hold with either enable low
    applyStimulus("load_5", 1'b1, 1'b0, 1'b0, 1'b1, 4'h5);
    for (int i = 0; i < 3; i++) applyStimulus("hold_cep", 1'b1, 1'b1, 1'b0, 1'b1, 4'hA);
    for (int i = 0; i < 3; i++) applyStimulus("hold_cet", 1'b1, 1'b1, 1'b1, 1'b0, 4'hA);
    checkOutput("hold_val", {4'd0, Q}, 8'd5);

    // TC follows CET without a clock
    applyStimulus("load_f", 1'b1, 1'b0, 1'b0, 1'b1, 4'hF);
    CET = 1'b0; #1;
    checkState("tc_cet0");
    CET = 1'b1; #1;
    checkState("tc_cet1");

    // Priority: reset beats load, load beats count
    applyStimulus("rst_vs_load", 1'b0, 1'b0, 1'b1, 1'b1, 4'h9);
    applyStimulus("load_f2", 1'b1, 1'b0, 1'b1, 1'b1, 4'hF);
    applyStimulus("load_vs_cnt", 1'b1, 1'b0, 1'b1, 1'b1, 4'h5);
    checkOutput("load_wins", {4'd0, Q}, 8'd5);

    // Full cycle from zero
    applyStimulus("clr", 1'b0, 1'b1, 1'b1, 1'b1, 4'h0);
    for (int i = 0; i < 16; i++) applyStimulus("full", 1'b1, 1'b1, 1'b1, 1'b1, 4'h0);
    checkOutput("full_back0", {4'd0, Q}, 8'd0);

    // Random stimulus against the reference model
    for (int i = 0; i < 400; i++) begin
      applyStimulus("rand",
                    1'($urandom_range(0, 24) != 0),
                    1'($urandom_range(0, 4) != 0),
                    1'($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 3) != 0),
                    4'($urandom));
      if ($urandom_range(0, 29) == 0) asyncReset("rand_async");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
